// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: response FSM states and
// starvation-counter helpers.
package riscv_defines;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESP_P0 = 2'd1,
        RESP_P1 = 2'd2
    } arb_state_t;

    localparam int unsigned STARVE_W = 4;

    function automatic logic [STARVE_W-1:0] sat_inc(
        input logic [STARVE_W-1:0] value,
        input logic [STARVE_W-1:0] limit
    );
        return (value >= limit) ? limit : value + 1'b1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: command towards the
// arbiter, grant and read response back.
interface dmem_port_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: fixed priority to the core LSU (port 0) with
// a starvation guard for the auxiliary master, plus a 1-cycle read return path.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no read response due this cycle
// RESP_P0 | memory read data this cycle belongs to port 0
// RESP_P1 | memory read data this cycle belongs to port 1
module dmem_arbiter
    import riscv_defines::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        start,
    dmem_port_if.slave  p0,
    dmem_port_if.slave  p1,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    arb_state_t          state, state_nxt;
    logic [STARVE_W-1:0] starve_cnt;
    logic                force_p1;
    logic                gnt0, gnt1;

    // Grants are purely combinational so a new access can issue in the same
    // cycle a previous read is returning.
    always_comb begin
        force_p1 = p1.req && (starve_cnt == LIMIT);
        gnt0     = start && p0.req && !force_p1;
        gnt1     = start && p1.req && (!p0.req || force_p1);
    end

    assign p0.gnt  = gnt0;
    assign p1.gnt  = gnt1;
    assign mem_req = gnt0 | gnt1;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (gnt0) begin
            mem_we    = p0.we;
            mem_addr  = p0.addr;
            mem_wdata = p0.wdata;
            mem_be    = p0.be;
        end else if (gnt1) begin
            mem_we    = p1.we;
            mem_addr  = p1.addr;
            mem_wdata = p1.wdata;
            mem_be    = p1.be;
        end
    end

    always_ff @(posedge clk) begin
        if (!start) begin
            starve_cnt <= '0;
        end else if (gnt1 || !p1.req) begin
            starve_cnt <= '0;
        end else if (gnt0) begin
            starve_cnt <= sat_inc(starve_cnt, LIMIT);
        end
    end

    always_ff @(posedge clk) begin
        if (!start) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        if (gnt0 && !p0.we) begin
            state_nxt = RESP_P0;
        end else if (gnt1 && !p1.we) begin
            state_nxt = RESP_P1;
        end
    end

    // Response outputs decode the registered state; data is steered only to
    // the owning port so the other port sees zeros.
    always_comb begin
        p0.rvalid = 1'b0;
        p0.rdata  = '0;
        p1.rvalid = 1'b0;
        p1.rdata  = '0;
        busy      = 1'b0;
        case (state)
            RESP_P0: begin
                p0.rvalid = 1'b1;
                p0.rdata  = mem_rdata;
                busy      = 1'b1;
            end
            RESP_P1: begin
                p1.rvalid = 1'b1;
                p1.rdata  = mem_rdata;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter: single reads, starvation rotation,
// back-to-back reads, writes and reset in the middle of a response.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        start;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        busy;
    int          checks = 0;
    int          failures = 0;

    dmem_port_if p0_if ();
    dmem_port_if p1_if ();

    dmem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk       (clk),
        .start     (start),
        .p0        (p0_if),
        .p1        (p1_if),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        p0_if.req = 0; p0_if.we = 0; p0_if.addr = 0; p0_if.wdata = 0; p0_if.be = 0;
        p1_if.req = 0; p1_if.we = 0; p1_if.addr = 0; p1_if.wdata = 0; p1_if.be = 0;
        mem_rdata = 0;
    endtask

    task automatic test_reset();
        start = 0;
        drive_idle();
        next_cycle();
        next_cycle();
        p0_if.req = 1; p1_if.req = 1;
        @(negedge clk);
        checks++;
        if ({p0_if.gnt, p1_if.gnt, mem_req} !== 3'b000) begin
            failures++; $display("FAIL rst_gnt actual=%b required=000", {p0_if.gnt, p1_if.gnt, mem_req});
        end
        checks++;
        if ({p0_if.rvalid, p1_if.rvalid, busy} !== 3'b000) begin
            failures++; $display("FAIL rst_resp actual=%b required=000", {p0_if.rvalid, p1_if.rvalid, busy});
        end
        checks++;
        if ({p0_if.rdata, p1_if.rdata} !== 64'h0) begin
            failures++; $display("FAIL rst_rdata actual=%h required=0", {p0_if.rdata, p1_if.rdata});
        end
        next_cycle();
        drive_idle();
        start = 1;
        next_cycle();
    endtask

    task automatic test_single_read();
        p0_if.req = 1; p0_if.we = 0; p0_if.addr = 32'h100; p0_if.be = 4'hf;
        @(negedge clk);
        checks++;
        if ({p0_if.gnt, p1_if.gnt, mem_req, mem_we} !== 4'b1010) begin
            failures++; $display("FAIL rd_gnt actual=%b required=1010", {p0_if.gnt, p1_if.gnt, mem_req, mem_we});
        end
        checks++;
        if (mem_addr !== 32'h100) begin
            failures++; $display("FAIL rd_addr actual=%h required=00000100", mem_addr);
        end
        next_cycle();
        drive_idle();
        mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if ({p0_if.rvalid, p1_if.rvalid, busy} !== 3'b101) begin
            failures++; $display("FAIL rd_rvalid actual=%b required=101", {p0_if.rvalid, p1_if.rvalid, busy});
        end
        checks++;
        if (p0_if.rdata !== 32'hDEADBEEF || p1_if.rdata !== 32'h0) begin
            failures++; $display("FAIL rd_rdata actual=%h/%h required=deadbeef/0", p0_if.rdata, p1_if.rdata);
        end
        next_cycle();
        mem_rdata = 0;
        @(negedge clk);
        checks++;
        if ({p0_if.rvalid, busy} !== 2'b00) begin
            failures++; $display("FAIL rd_done actual=%b required=00", {p0_if.rvalid, busy});
        end
        next_cycle();
    endtask

    task automatic test_starvation();
        logic exp_p1;
        p0_if.req = 1; p0_if.we = 1; p0_if.addr = 32'hA0;
        p1_if.req = 1; p1_if.we = 1; p1_if.addr = 32'hB0;
        for (int i = 0; i < 10; i++) begin
            exp_p1 = (i % 5 == 4);
            @(negedge clk);
            checks++;
            if ({p0_if.gnt, p1_if.gnt} !== {!exp_p1, exp_p1}) begin
                failures++; $display("FAIL starve_gnt cyc=%0d actual=%b required=%b", i, {p0_if.gnt, p1_if.gnt}, {!exp_p1, exp_p1});
            end
            checks++;
            if (mem_addr !== (exp_p1 ? 32'hB0 : 32'hA0)) begin
                failures++; $display("FAIL starve_addr cyc=%0d actual=%h required=%h", i, mem_addr, exp_p1 ? 32'hB0 : 32'hA0);
            end
            next_cycle();
        end
        drive_idle();
        next_cycle();
    endtask

    task automatic test_back_to_back();
        p0_if.req = 1; p0_if.we = 0; p0_if.addr = 32'h10;
        @(negedge clk);
        checks++;
        if ({p0_if.gnt, p1_if.gnt} !== 2'b10) begin
            failures++; $display("FAIL b2b_gnt0 actual=%b required=10", {p0_if.gnt, p1_if.gnt});
        end
        next_cycle();
        p0_if.req = 0;
        p1_if.req = 1; p1_if.we = 0; p1_if.addr = 32'h20;
        mem_rdata = 32'h11111111;
        @(negedge clk);
        checks++;
        if ({p0_if.rvalid, p1_if.rvalid, p1_if.gnt, busy} !== 4'b1011) begin
            failures++; $display("FAIL b2b_cyc1 actual=%b required=1011", {p0_if.rvalid, p1_if.rvalid, p1_if.gnt, busy});
        end
        checks++;
        if (p0_if.rdata !== 32'h11111111 || mem_addr !== 32'h20) begin
            failures++; $display("FAIL b2b_data1 actual=%h/%h required=11111111/00000020", p0_if.rdata, mem_addr);
        end
        next_cycle();
        drive_idle();
        mem_rdata = 32'h22222222;
        @(negedge clk);
        checks++;
        if ({p0_if.rvalid, p1_if.rvalid} !== 2'b01 || p1_if.rdata !== 32'h22222222 || p0_if.rdata !== 32'h0) begin
            failures++; $display("FAIL b2b_cyc2 actual=%b %h/%h required=01 22222222/0", {p0_if.rvalid, p1_if.rvalid}, p1_if.rdata, p0_if.rdata);
        end
        next_cycle();
        mem_rdata = 0;
        @(negedge clk);
        checks++;
        if ({p0_if.rvalid, p1_if.rvalid, busy} !== 3'b000) begin
            failures++; $display("FAIL b2b_cyc3 actual=%b required=000", {p0_if.rvalid, p1_if.rvalid, busy});
        end
        next_cycle();
    endtask

    task automatic test_write();
        p1_if.req = 1; p1_if.we = 1; p1_if.addr = 32'h40; p1_if.wdata = 32'h1234; p1_if.be = 4'h3;
        @(negedge clk);
        checks++;
        if ({p1_if.gnt, mem_req, mem_we, mem_be} !== 7'b111_0011) begin
            failures++; $display("FAIL wr_cmd actual=%b required=1110011", {p1_if.gnt, mem_req, mem_we, mem_be});
        end
        checks++;
        if (mem_wdata !== 32'h1234 || mem_addr !== 32'h40) begin
            failures++; $display("FAIL wr_data actual=%h/%h required=00001234/00000040", mem_wdata, mem_addr);
        end
        next_cycle();
        drive_idle();
        mem_rdata = 32'h99999999;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({p0_if.rvalid, p1_if.rvalid, busy, mem_we} !== 4'b0000) begin
                failures++; $display("FAIL wr_noresp cyc=%0d actual=%b required=0000", i, {p0_if.rvalid, p1_if.rvalid, busy, mem_we});
            end
            next_cycle();
        end
        mem_rdata = 0;
    endtask

    task automatic test_reset_mid();
        p0_if.req = 1; p0_if.we = 0; p0_if.addr = 32'h200;
        @(negedge clk);
        checks++;
        if (p0_if.gnt !== 1'b1) begin
            failures++; $display("FAIL rstm_gnt actual=%b required=1", p0_if.gnt);
        end
        next_cycle();
        start = 0;
        mem_rdata = 32'h5555AAAA;
        @(negedge clk);
        checks++;
        if ({p0_if.gnt, mem_req} !== 2'b00) begin
            failures++; $display("FAIL rstm_nogrant actual=%b required=00", {p0_if.gnt, mem_req});
        end
        next_cycle();
        drive_idle();
        start = 1;
        mem_rdata = 32'h5555AAAA;
        @(negedge clk);
        checks++;
        if ({p0_if.rvalid, p1_if.rvalid, busy} !== 3'b000 || p0_if.rdata !== 32'h0) begin
            failures++; $display("FAIL rstm_drop actual=%b %h required=000 0", {p0_if.rvalid, p1_if.rvalid, busy}, p0_if.rdata);
        end
        next_cycle();
        p0_if.req = 1; p0_if.we = 0; p0_if.addr = 32'h300;
        mem_rdata = 0;
        @(negedge clk);
        checks++;
        if (p0_if.gnt !== 1'b1 || mem_addr !== 32'h300) begin
            failures++; $display("FAIL rstm_regnt actual=%b %h required=1 00000300", p0_if.gnt, mem_addr);
        end
        next_cycle();
        drive_idle();
        mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        checks++;
        if (p0_if.rvalid !== 1'b1 || p0_if.rdata !== 32'hCAFEF00D || busy !== 1'b1) begin
            failures++; $display("FAIL rstm_reread actual=%b %h %b required=1 cafef00d 1", p0_if.rvalid, p0_if.rdata, busy);
        end
        next_cycle();
        mem_rdata = 0;
        next_cycle();
    endtask

    task automatic test_starve_toggle();
        logic [8:0] p1_req_pat;
        logic [8:0] p1_gnt_exp;
        p1_req_pat = 9'b1_1111_0111;   // bit i = p1_req in cycle i
        p1_gnt_exp = 9'b1_0000_0000;
        p0_if.req = 1; p0_if.we = 1; p0_if.addr = 32'hC0;
        p1_if.we = 1; p1_if.addr = 32'hD0;
        for (int i = 0; i < 9; i++) begin
            p1_if.req = p1_req_pat[i];
            @(negedge clk);
            checks++;
            if ({p0_if.gnt, p1_if.gnt} !== {!p1_gnt_exp[i], p1_gnt_exp[i]}) begin
                failures++; $display("FAIL toggle_gnt cyc=%0d actual=%b required=%b", i, {p0_if.gnt, p1_if.gnt}, {!p1_gnt_exp[i], p1_gnt_exp[i]});
            end
            next_cycle();
        end
        drive_idle();
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_starvation();
        test_back_to_back();
        test_write();
        test_reset_mid();
        test_starve_toggle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, 4, count of consecutive contested cycles lost by port 1 before it is force-granted (range 1..15).
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 start  in  1  reset; synchronous, active-low; state resets while start==0.
REQ-004 pN_req  in  1  access request, N in {0,1}; port 0 is the core LSU, port 1 is the auxiliary (debug/DMA) master.
REQ-005 pN_we  in  1  1=write, 0=read.
REQ-006 pN_addr  in  32  byte address.
REQ-007 pN_wdata  in  32  write data.
REQ-008 pN_be  in  4  byte enables.
REQ-009 pN_gnt  out  1  request accepted this cycle (combinational).
REQ-010 pN_rvalid  out  1  read data valid; registered pulse.
REQ-011 pN_rdata  out  32  read data, qualified by pN_rvalid.
REQ-012 mem_req, mem_we, mem_addr[31:0], mem_wdata[31:0], mem_be[3:0]  out  memory command, driven from the granted port.
REQ-013 mem_rdata  in  32  memory read data, valid exactly one cycle after a read command.
REQ-014 busy  out  1  high while a read response is outstanding, for the hazard unit.

Function
REQ-015 At most one of p0_gnt/p1_gnt SHALL be high in any cycle; pN_gnt SHALL never be high while pN_req is low.
REQ-016 Default priority SHALL be port 0 wins when both request.
REQ-017 starve_cnt (4 bit) SHALL increment, saturating at STARVE_LIMIT, on each cycle with p1_req=1 and p0_gnt=1; it SHALL clear on p1_gnt or when p1_req=0.
REQ-018 When starve_cnt==STARVE_LIMIT and p1_req=1, port 1 SHALL be granted regardless of p0_req.
REQ-019 mem_req SHALL equal p0_gnt|p1_gnt; mem_we/addr/wdata/be SHALL come from the granted port, and SHALL be zero when there is no grant.
REQ-020 Response FSM states: IDLE, RESP_P0, RESP_P1. A granted read SHALL move to RESP_<owner>; a write or no grant SHALL move to IDLE.
REQ-021 In RESP_N, pN_rvalid=1 and pN_rdata=mem_rdata; the other port's rvalid=0 and rdata=0. Read latency SHALL be exactly 1 cycle from grant.
REQ-022 A new grant SHALL be allowed in the same cycle a response is delivered (back-to-back throughput of 1 access per cycle).
REQ-023 Writes SHALL produce no rvalid.
REQ-024 busy SHALL be 1 in RESP_P0/RESP_P1 and 0 in IDLE.

Reset
REQ-025 When start==0, FSM=IDLE and starve_cnt=0; all rvalid, rdata and busy outputs SHALL be 0 on the following cycle.
REQ-026 When start==0, no grants are issued and mem_req=0, combinationally.
REQ-027 A response pending when reset asserts SHALL be dropped, with no rvalid after reset release.

Structure
REQ-028 The enum arb_state_t {IDLE, RESP_P0, RESP_P1} SHALL reside in package riscv_defines.
REQ-029 The module SHALL be self-contained with no sub-module; grant logic and FSM live in one file.

Verification
REQ-030 p0 read addr=0x100 alone; mem_rdata=0xDEADBEEF -> p0_gnt same cycle, p0_rvalid=1 and p0_rdata=0xDEADBEEF next cycle, busy=1 for that cycle.
REQ-031 p0 and p1 requesting every cycle, STARVE_LIMIT=4 -> p0 granted cycles 0-3, p1 granted cycle 4, starve_cnt back to 0, pattern repeats.
REQ-032 Back-to-back reads p0@0x10 then p1@0x20 -> p0_rvalid in cycle 1, p1_rvalid in cycle 2, never both in one cycle.
REQ-033 p1 write be=0x3 wdata=0x1234 -> mem_we=1, mem_be=0x3 in the grant cycle, no p1_rvalid afterwards.
REQ-034 start driven low in the cycle after a p0 read grant -> p0_rvalid=0 and busy=0 on the following cycle; after release, the first new read completes normally.
REQ-035 p1_req toggled low for 1 cycle during contention at starve_cnt=3 -> counter clears and p1 waits a further 4 contested cycles.
